sprite_slot_shifter: RTL
========================

Name: sprite_slot_shifter

Overview:
Per-line sprite pixel generator that drives the per-slot inputs of combined_priority_encoder. The sprite evaluator loads up to NUM_SLOTS sprite rows (x position, 2-bit pixel row, palette bit) into shadow registers during line N. On line_start, the shadow registers are promoted to active, and each slot emits its row one pixel per pixel-enable when hcount reaches its x. Outputs are registered, and the encoder consumes them directly.

Parameters:
NUM_SLOTS, 9, number of sprite slots (encoder input count)
SPRITE_W, 16, pixels per sprite row
PIX_W, 2, bits per pixel; value 0 = transparent
X_W, 10, width of x position / hcount

Ports:
clk  in  1  pixel-domain clock
reset_n  in  1  asynchronous active-low reset
line_start  in  1  one-cycle pulse at start of each scanline; promotes shadow to active
hcount  in  X_W  current horizontal pixel column
pix_en  in  1  pixel advance strobe (one per displayed pixel)
load_valid  in  1  evaluator presents a slot load
load_ready  out  1  block accepts load this cycle
load_slot  in  4  target slot index
load_x  in  X_W  sprite left column
load_row  in  SPRITE_W*PIX_W  pixel row; pixel k at bits [k*PIX_W +: PIX_W], k=0 leftmost
load_palette  in  1  palette select for slot
pixel_data_out  out  NUM_SLOTS x PIX_W  per-slot pixel (unpacked array, index = slot)
palette_data_out  out  NUM_SLOTS x 1  per-slot palette bit
slot_active  out  NUM_SLOTS  slot is in WAIT or SHIFT this line

Behaviour:
- Reset (async, reset_n low):
  - all pixel_data_out = 0, palette_data_out = 0, slot_active = 0.
  - All shadow-valid bits cleared; all slots IDLE.
  - load_ready = 0 while in reset, then 1 from the first cycle after release.
- Load handshake:
  - Transfer occurs when load_valid && load_ready at a clock edge.
  - Writes shadow[load_slot] = {x, row, palette} and sets shadow_valid[load_slot].
  - load_ready = !line_start; a load presented during line_start is not accepted and must be held.
  - load_slot >= NUM_SLOTS: accepted and discarded; no state change.
  - Reloading the same slot before line_start overwrites it (last write wins).
- line_start edge, per slot:
  - active <= shadow.
  - State <= WAIT if shadow_valid, else IDLE.
  - Pixel counter <= 0; shadow_valid <= 0.
  - Outputs <= 0 for that slot.
  - line_start takes precedence over pix_en in the same cycle.
- Per-slot FSM (advances only on pix_en cycles; outputs hold otherwise):
  - IDLE: output 0.
  - WAIT: if hcount == x, output pixel 0 with palette, counter <= 1, go to SHIFT. Otherwise output 0.
  - SHIFT: output pixel[counter], counter++. Go to DONE after emitting pixel SPRITE_W-1.
  - DONE: output 0 until next line_start.
- Latency: a pix_en cycle with hcount = h produces the pixel for column h on the outputs at the following clock edge (1 cycle).
- palette_data_out carries the slot palette only while in WAIT-hit/SHIFT; it is 0 otherwise.
- Transparent pixels (0) inside a row are output as 0, with palette still driven.
- A row extending past the visible line simply stops advancing; it is cleared at the next line_start. There is no wrap-around.
- slot_active = state ∈ {WAIT, SHIFT}.

Optional Feature:
SPRITE_HFLIP_EN:
- Defined: adds input port load_hflip (1 bit), stored per slot. When set, the slot emits pixel SPRITE_W-1 first, down to pixel 0.
- Undefined: no port; rows always emit pixel 0 first.

Test Plan:
- Reset → release: all outputs 0 and load_ready=1 one cycle after release. Line_start with no loads leaves all slots IDLE and outputs 0 for a full line.
- Load slot 2, x=5, row=32'hFFFF_FFFF (all 2'b11), palette=1; then line_start. Sweep hcount 0..30 with pix_en every cycle → slot 2 outputs 2'b11/pal=1 for hcount 5..20 (visible one cycle later), 0 elsewhere. Feeding the encoder yields pixel_out=11, palette_out=1 over the same span.
- Load slots 1 (x=10, row pixels alternating 01/00) and 3 (x=12, all 10) → encoder output follows slot 1 where nonzero, slot 3 where slot 1 is transparent.
- Assert load_valid in the same cycle as line_start → load_ready=0, no transfer. The load is accepted the next cycle, and the new data is active only after the following line_start.
- Deassert pix_en for 3 cycles mid-SHIFT → outputs hold the last pixel and the counter does not advance. Assert reset_n=0 mid-SHIFT → outputs 0 immediately (async) and shadow cleared.
- load_slot=12 → accepted and ignored. With SPRITE_HFLIP_EN, row pixels 0..15 = 1,0,0,…,0 and hflip=1 → 2'b01 appears at column x+15.

Source files
------------

// File: rtl/sprite_slot_shifter.sv
`default_nettype none
// ============================================================================
// Module  : sprite_slot_shifter
// Purpose : Per-slot sprite row shifter feeding a sprite priority encoder.
//           Optional macro SPRITE_HFLIP_EN adds per-slot horizontal flip.
// Revision: 1.0 - initial release
// ============================================================================
module sprite_slot_shifter #(
  parameter int NUM_SLOTS = 9,
  parameter int SPRITE_W  = 16,
  parameter int PIX_W     = 2,
  parameter int X_W       = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      line_start,
  input  logic [X_W-1:0]            hcount,
  input  logic                      pix_en,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [3:0]                load_slot,
  input  logic [X_W-1:0]            load_x,
  input  logic [SPRITE_W*PIX_W-1:0] load_row,
  input  logic                      load_palette,
`ifdef SPRITE_HFLIP_EN
  input  logic                      load_hflip,
`endif
  output logic [PIX_W-1:0]          pixel_data_out [NUM_SLOTS],
  output logic [NUM_SLOTS-1:0]      palette_data_out,
  output logic [NUM_SLOTS-1:0]      slot_active
);

  localparam int                CNT_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(SPRITE_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } slot_state_t;

  logic r_ready;
  logic w_load_fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ready <= 1'b0;
    else          r_ready <= 1'b1;
  end

  // Loads are refused on line_start so shadow promotion never races a write.
  assign load_ready  = r_ready && !line_start;
  assign w_load_fire = load_valid && load_ready;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    localparam logic [3:0] C_SLOT_ID = 4'(s);

    logic [X_W-1:0]            r_sh_x, r_act_x;
    logic [SPRITE_W*PIX_W-1:0] r_sh_row, r_act_row;
    logic                      r_sh_pal, r_act_pal, r_sh_vld;
    slot_state_t               r_state, w_state_nx;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nx, w_sel, w_idx;
    logic [PIX_W-1:0]          r_pix, w_pix_nx, w_pix_sel;
    logic                      r_pal, w_pal_nx, w_wr;

    assign w_wr = w_load_fire && (load_slot == C_SLOT_ID);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sh_x    <= '0;
        r_sh_row  <= '0;
        r_sh_pal  <= 1'b0;
        r_sh_vld  <= 1'b0;
        r_act_x   <= '0;
        r_act_row <= '0;
        r_act_pal <= 1'b0;
      end else if (line_start) begin
        r_act_x   <= r_sh_x;
        r_act_row <= r_sh_row;
        r_act_pal <= r_sh_pal;
        r_sh_vld  <= 1'b0;
      end else if (w_wr) begin
        r_sh_x    <= load_x;
        r_sh_row  <= load_row;
        r_sh_pal  <= load_palette;
        r_sh_vld  <= 1'b1;
      end
    end

    // In WAIT the first emitted pixel is always logical pixel 0.
    assign w_sel = (r_state == S_WAIT) ? '0 : r_cnt;

`ifdef SPRITE_HFLIP_EN
    logic r_sh_hflip, r_act_hflip;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sh_hflip  <= 1'b0;
        r_act_hflip <= 1'b0;
      end else if (line_start) begin
        r_act_hflip <= r_sh_hflip;
      end else if (w_wr) begin
        r_sh_hflip  <= load_hflip;
      end
    end

    assign w_idx = r_act_hflip ? (C_LAST - w_sel) : w_sel;
`else
    assign w_idx = w_sel;
`endif

    assign w_pix_sel = r_act_row[w_idx*PIX_W +: PIX_W];

    always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_pix_nx   = r_pix;
      w_pal_nx   = r_pal;
      if (line_start) begin
        w_state_nx = r_sh_vld ? S_WAIT : S_IDLE;
        w_cnt_nx   = '0;
        w_pix_nx   = '0;
        w_pal_nx   = 1'b0;
      end else if (pix_en) begin
        w_pix_nx = '0;
        w_pal_nx = 1'b0;
        case (r_state)
          S_WAIT: begin
            if (hcount == r_act_x) begin
              w_pix_nx   = w_pix_sel;
              w_pal_nx   = r_act_pal;
              w_cnt_nx   = CNT_W'(1);
              w_state_nx = (SPRITE_W == 1) ? S_DONE : S_SHIFT;
            end
          end
          S_SHIFT: begin
            w_pix_nx = w_pix_sel;
            w_pal_nx = r_act_pal;
            w_cnt_nx = r_cnt + CNT_W'(1);
            if (r_cnt == C_LAST) w_state_nx = S_DONE;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_pix   <= '0;
        r_pal   <= 1'b0;
      end else begin
        r_state <= w_state_nx;
        r_cnt   <= w_cnt_nx;
        r_pix   <= w_pix_nx;
        r_pal   <= w_pal_nx;
      end
    end

    assign pixel_data_out[s]   = r_pix;
    assign palette_data_out[s] = r_pal;
    assign slot_active[s]      = (r_state == S_WAIT) || (r_state == S_SHIFT);
  end

endmodule
`default_nettype wire
